axil_master_if: RTL and testbench
=================================

// Module: axil_master_if
// PURPOSE
//  AXI4-Lite master interface: the initiator end of the bus that AXI_UART-style peripherals respond to.
//  Takes one simple command (read or write) from a core, drives the AXI4-Lite master channels,
//  and returns data and response to the core. One transaction is outstanding at a time.
//  A watchdog aborts any phase the slave never completes.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32   address width, command and AW/AR
//  C_M_AXI_DATA_WIDTH  32   data width; strobe width = /8
//  C_TIMEOUT_CYCLES    1024 cycles to wait per bus phase; 0 = watchdog disabled
// PORTS
//  M_AXI_ACLK     in   1    clock; all logic on posedge
//  M_AXI_ARESETN  in   1    asynchronous, active-low reset
//  cmd_valid      in   1    command offered
//  cmd_ready      out  1    command accepted when valid&&ready
//  cmd_write      in   1    1 = write, 0 = read
//  cmd_addr       in   AW   byte address
//  cmd_wdata      in   DW   write data
//  cmd_wstrb      in   DW/8 write byte strobes
//  rsp_valid      out  1    response offered
//  rsp_ready      in   1    core takes the response
//  rsp_write      out  1    response is for a write
//  rsp_rdata      out  DW   read data (0 for writes)
//  rsp_resp       out  2    AXI resp; 2'b10 (SLVERR) on timeout
//  rsp_timeout    out  1    response was produced by the watchdog
//  M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY,
//  M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY,
//  M_AXI_RDATA/RRESP/RVALID/RREADY   standard AXI4-Lite master directions and widths
// BEHAVIOUR
//  - Outputs are registered. On reset: all VALIDs, BREADY, RREADY, rsp_* and cmd_ready are 0;
//    AWADDR, WDATA, WSTRB and ARADDR are 0; FSM is in IDLE.
//  - FSM states: IDLE, WR (AW/W), WR_B, RD_AR, RD_R, RSP.
//  - IDLE: cmd_ready=1 and BREADY=RREADY=1 (these sink stray late responses, which are discarded).
//    The first cycle after reset release registers these to 1.
//  - Command handshake latches the command into the AXI registers. The next state is WR or RD_AR;
//    in both, cmd_ready, BREADY and RREADY go to 0.
//  - WR: AWVALID=WVALID=1 from the next cycle. Each VALID drops the cycle after its own handshake,
//    because AW and W complete independently (aw_done / w_done flags).
//    When both are done: state WR_B with BREADY=1.
//  - WR_B: on BVALID&&BREADY, capture BRESP; rsp_write=1, rsp_rdata=0; go to RSP.
//  - RD_AR: ARVALID=1 until ARREADY. Then RD_R with RREADY=1.
//    On RVALID&&RREADY, capture RDATA/RRESP; go to RSP.
//  - RSP: rsp_valid=1 and rsp_* stable until rsp_ready; then IDLE, one cycle later cmd_ready=1.
//  - VALIDs are never withdrawn before their handshake, except on timeout.
//    Address, data and strobe stay stable while their VALID is high.
//  - Latency with a zero-wait slave and rsp_ready=1: cmd accept at T0, AXI VALID at T1,
//    B/R handshake at T2, rsp_valid at T3, cmd_ready again at T5.
//  - Watchdog: a counter clears on entry to WR, WR_B, RD_AR and RD_R.
//    If the count reaches C_TIMEOUT_CYCLES with no completing handshake: drop all VALIDs and READYs,
//    go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
//    Width is $clog2(C_TIMEOUT_CYCLES+1); it saturates and never wraps.
//  - Simultaneous handshakes: AW and W completing in the same cycle go straight to WR_B.
//    A handshake in the same cycle the watchdog expires wins; there is no timeout.
//  - Reset mid-transaction aborts immediately to the reset values. No response is produced.
// STRUCTURE
//  - axil_pkg: axi_resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3),
//    axil_mst_state_t enum, RESP_TIMEOUT constant.
//  - Sub-module axil_timeout_ctr (clear, enable, expired); the FSM and registers stay in the top.
// TESTING
//  - Write 0xDEADBEEF to 0x4, wstrb 0xF, zero-wait slave -> AW/W at T1, B OKAY, rsp_valid at T3, rsp_resp=0.
//  - Read 0x8, slave returns 0x000000A5 after 5 wait cycles -> rsp_rdata=0xA5, ARADDR stable throughout.
//  - Slave takes W 3 cycles before AW -> WVALID drops after W; B phase starts only after AW completes.
//  - C_TIMEOUT_CYCLES=16, slave never raises ARREADY -> at cycle 16: ARVALID=0, rsp_resp=2, rsp_timeout=1.
//    A later stray RVALID in IDLE is absorbed.
//  - rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0; a second cmd_valid waits.
//  - Deassert ARESETN while in WR_B -> all outputs go to reset values; next command runs normally.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pkg
// Brief    : Shared types and constants for the AXI4-Lite master interface.
// Revision : 1.0 - initial release
// ============================================================================
package axil_pkg;

   // AXI response codes
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   // Master FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_WR_B  = 3'd2,
      ST_RD_AR = 3'd3,
      ST_RD_R  = 3'd4,
      ST_RSP   = 3'd5
   } axil_mst_state_t;

   // Response code reported when the watchdog aborts a phase
   localparam axi_resp_t RESP_TIMEOUT = SLVERR;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : axil_timeout_ctr
// Brief    : Per-phase watchdog. Counts cycles spent in a bus phase and
//            flags expiry on the cycle that completes TIMEOUT_CYCLES of
//            waiting. Saturates, never wraps. TIMEOUT_CYCLES = 0 disables it.
// Revision : 1.0 - initial release
// ============================================================================
module axil_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_wd_off
         logic w_unused;
         assign w_unused = &{1'b0, clk, rst_n, clear, enable};
         assign expired  = 1'b0;
      end else begin : g_wd_on
         // Count value on the last permitted waiting cycle, and saturation ceiling
         localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
         localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(TIMEOUT_CYCLES);

         logic [c_cnt_w-1:0] r_cnt;

         // Cycle counter: cleared between phases, saturating while enabled
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (clear) begin
               r_cnt <= '0;
            end else if (enable && (r_cnt != c_max)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign expired = enable && (r_cnt >= c_last);
      end
   endgenerate

endmodule : axil_timeout_ctr
`default_nettype wire

// File: rtl/axil_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_master_if
// Brief    : AXI4-Lite master. Accepts one read/write command at a time from
//            a core, runs it on the bus and returns data/response. A
//            watchdog aborts any phase the slave never completes.
// Revision : 1.0 - initial release
// ============================================================================
module axil_master_if
   import axil_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES   = 1024
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESETN,
   // core command
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   // core response
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            rsp_timeout,
   // write address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   // write data
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   // write response
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   // read address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   // read data
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int c_strb_w = C_M_AXI_DATA_WIDTH / 8;

   axil_mst_state_t                r_state;
   logic [C_M_AXI_ADDR_WIDTH-1:0]  r_awaddr;
   logic [C_M_AXI_ADDR_WIDTH-1:0]  r_araddr;
   logic [C_M_AXI_DATA_WIDTH-1:0]  r_wdata;
   logic [c_strb_w-1:0]            r_wstrb;
   logic                           r_awvalid;
   logic                           r_wvalid;
   logic                           r_bready;
   logic                           r_arvalid;
   logic                           r_rready;
   logic                           r_aw_done;
   logic                           r_w_done;
   logic                           r_cmd_ready;
   logic                           r_rsp_valid;
   logic                           r_rsp_write;
   logic [C_M_AXI_DATA_WIDTH-1:0]  r_rsp_rdata;
   logic [1:0]                     r_rsp_resp;
   logic                           r_rsp_timeout;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_b_hs;
   logic w_ar_hs;
   logic w_r_hs;
   logic w_aw_fin;
   logic w_w_fin;
   logic w_phase_done;
   logic w_wd_enable;
   logic w_wd_clear;
   logic w_wd_expired;
   logic w_timeout;

   assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
   assign w_w_hs   = r_wvalid  & M_AXI_WREADY;
   assign w_b_hs   = r_bready  & M_AXI_BVALID;
   assign w_ar_hs  = r_arvalid & M_AXI_ARREADY;
   assign w_r_hs   = r_rready  & M_AXI_RVALID;
   assign w_aw_fin = r_aw_done | w_aw_hs;
   assign w_w_fin  = r_w_done  | w_w_hs;

   // Which states are watched, and whether the current phase completes this cycle
   always_comb begin
      w_wd_enable  = 1'b0;
      w_phase_done = 1'b0;
      case (r_state)
         ST_WR:    begin w_wd_enable = 1'b1; w_phase_done = w_aw_fin & w_w_fin; end
         ST_WR_B:  begin w_wd_enable = 1'b1; w_phase_done = w_b_hs;             end
         ST_RD_AR: begin w_wd_enable = 1'b1; w_phase_done = w_ar_hs;            end
         ST_RD_R:  begin w_wd_enable = 1'b1; w_phase_done = w_r_hs;             end
         default:  ;
      endcase
   end

   // The counter restarts whenever a phase ends, so each new phase starts at zero.
   // A completing handshake in the expiry cycle takes priority over the abort.
   assign w_wd_clear = ~w_wd_enable | w_phase_done;
   assign w_timeout  = w_wd_expired & ~w_phase_done;

   axil_timeout_ctr #(
      .TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
   ) u_wd (
      .clk     (M_AXI_ACLK),
      .rst_n   (M_AXI_ARESETN),
      .clear   (w_wd_clear),
      .enable  (w_wd_enable),
      .expired (w_wd_expired)
   );

   // Transaction FSM with all bus and core outputs registered
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_state       <= ST_IDLE;
         r_awaddr      <= '0;
         r_araddr      <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_write   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Ready for a command; B/R readies drain stray late responses
               r_cmd_ready <= 1'b1;
               r_bready    <= 1'b1;
               r_rready    <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_bready    <= 1'b0;
                  r_rready    <= 1'b0;
                  r_aw_done   <= 1'b0;
                  r_w_done    <= 1'b0;
                  if (cmd_write) begin
                     r_awaddr  <= cmd_addr;
                     r_wdata   <= cmd_wdata;
                     r_wstrb   <= cmd_wstrb;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR;
                  end else begin
                     r_araddr  <= cmd_addr;
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_AR;
                  end
               end
            end
            ST_WR: begin
               // AW and W retire independently
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WR_B;
               end
            end
            ST_WR_B: begin
               if (w_b_hs) begin
                  r_bready      <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_write   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_resp    <= M_AXI_BRESP;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RSP;
               end
            end
            ST_RD_AR: begin
               if (w_ar_hs) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_R;
               end
            end
            ST_RD_R: begin
               if (w_r_hs) begin
                  r_rready      <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_write   <= 1'b0;
                  r_rsp_rdata   <= M_AXI_RDATA;
                  r_rsp_resp    <= M_AXI_RRESP;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Watchdog abort overrides whatever the phase logic above scheduled
         if (w_timeout) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= (r_state == ST_WR) || (r_state == ST_WR_B);
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_TIMEOUT;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_RSP;
         end
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_write     = r_rsp_write;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign rsp_timeout   = r_rsp_timeout;
   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;

endmodule : axil_master_if
`default_nettype wire

// File: tb/tb_axil_master_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_master_if
// Brief    : Directed self-checking bench for axil_master_if with a
//            configurable-latency AXI4-Lite slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_master_if;

   logic        clk;
   logic        ARESETN;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   int n_assert = 0;
   int n_fail   = 0;

   // slave knobs (written only by the stimulus block)
   int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   bit          ar_never = 0;
   logic [1:0]  bresp_val = 2'b00;
   logic [31:0] rdata_val = 32'h0;
   int          stray_r_req = 0;
   int          flush_req   = 0;

   axil_master_if #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .C_TIMEOUT_CYCLES   (16)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (ARESETN),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_write     (rsp_write),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .rsp_timeout   (rsp_timeout),
      .M_AXI_AWADDR  (M_AXI_AWADDR),
      .M_AXI_AWVALID (M_AXI_AWVALID),
      .M_AXI_AWREADY (M_AXI_AWREADY),
      .M_AXI_WDATA   (M_AXI_WDATA),
      .M_AXI_WSTRB   (M_AXI_WSTRB),
      .M_AXI_WVALID  (M_AXI_WVALID),
      .M_AXI_WREADY  (M_AXI_WREADY),
      .M_AXI_BRESP   (M_AXI_BRESP),
      .M_AXI_BVALID  (M_AXI_BVALID),
      .M_AXI_BREADY  (M_AXI_BREADY),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "bench time limit reached");
   end

   // Slave model: decides its outputs on the falling edge, using the handshakes
   // it predicted for the rising edge just passed.
   initial begin : slave
      int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      bit  got_aw, got_w, got_ar;
      bit  hs_aw, hs_w, hs_b, hs_ar, hs_r;
      int  stray_seen, flush_seen;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      got_aw = 0; got_w = 0; got_ar = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      stray_seen = 0; flush_seen = 0;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      forever begin
         @(negedge clk);
         if (hs_aw) got_aw = 1;
         if (hs_w)  got_w  = 1;
         if (hs_ar) got_ar = 1;
         if (hs_b)  M_AXI_BVALID = 0;
         if (hs_r)  M_AXI_RVALID = 0;
         if (flush_req != flush_seen) begin
            flush_seen = flush_req;
            got_aw = 0; got_w = 0; got_ar = 0; b_cnt = 0; r_cnt = 0;
         end
         if (stray_r_req != stray_seen) begin
            stray_seen = stray_r_req;
            got_ar = 1;
         end
         if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_wait); aw_cnt++; end
         else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
         if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_wait); w_cnt++; end
         else begin M_AXI_WREADY = 0; w_cnt = 0; end
         if (M_AXI_ARVALID) begin M_AXI_ARREADY = !ar_never && (ar_cnt >= ar_wait); ar_cnt++; end
         else begin M_AXI_ARREADY = 0; ar_cnt = 0; end
         if (got_aw && got_w && !M_AXI_BVALID) begin
            if (b_cnt >= b_wait) begin
               M_AXI_BVALID = 1; M_AXI_BRESP = bresp_val;
               got_aw = 0; got_w = 0; b_cnt = 0;
            end else b_cnt++;
         end
         if (got_ar && !M_AXI_RVALID) begin
            if (r_cnt >= r_wait) begin
               M_AXI_RVALID = 1; M_AXI_RDATA = rdata_val; M_AXI_RRESP = 2'b00;
               got_ar = 0; r_cnt = 0;
            end else r_cnt++;
         end
         hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
         hs_w  = M_AXI_WVALID  && M_AXI_WREADY;
         hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
         hs_b  = M_AXI_BVALID  && M_AXI_BREADY;
         hs_r  = M_AXI_RVALID  && M_AXI_RREADY;
      end
   end

   // Address/data/strobe must not move while their VALID is held
   int          stab_viol = 0;
   logic        p_awv = 0, p_wv = 0, p_arv = 0;
   logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
   logic [3:0]  p_wstrb = 0;
   always @(negedge clk) begin
      if (p_awv && M_AXI_AWVALID && (M_AXI_AWADDR !== p_awaddr)) stab_viol++;
      if (p_wv && M_AXI_WVALID && ({M_AXI_WDATA, M_AXI_WSTRB} !== {p_wdata, p_wstrb})) stab_viol++;
      if (p_arv && M_AXI_ARVALID && (M_AXI_ARADDR !== p_araddr)) stab_viol++;
      p_awv = M_AXI_AWVALID; p_awaddr = M_AXI_AWADDR;
      p_wv  = M_AXI_WVALID;  p_wdata  = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
      p_arv = M_AXI_ARVALID; p_araddr = M_AXI_ARADDR;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] all_outs();
      return {17'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
              cmd_ready, rsp_valid, rsp_write, rsp_timeout, rsp_resp,
              M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR, rsp_rdata};
   endfunction

   initial begin : stim
      int lat;
      ARESETN = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 1;
      repeat (3) tick();
      chk("reset_outputs", all_outs(), 160'(0));
      ARESETN = 1;
      tick();
      chk("idle_ready", 160'({cmd_ready, M_AXI_BREADY, M_AXI_RREADY}), 160'(3'b111));

      // ---- zero-wait write: 0xDEADBEEF to 0x4
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
      tick();                                                    // T1
      cmd_valid = 0;
      chk("wr_t1_valids", 160'({M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, M_AXI_BREADY}), 160'(4'b1100));
      chk("wr_t1_payload", 160'({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}), 160'({32'h4, 32'hDEADBEEF, 4'hF}));
      tick();                                                    // T2
      chk("wr_t2_b_phase", 160'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid}), 160'(4'b0010));
      tick();                                                    // T3
      chk("wr_t3_rsp", 160'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}),
          160'({3'b110, 2'b00, 32'h0}));
      tick();                                                    // T4
      chk("wr_t4_idle", 160'({rsp_valid, cmd_ready}), 160'(2'b00));
      tick();                                                    // T5
      chk("wr_t5_cmd_ready", 160'(cmd_ready), 160'(1'b1));

      // ---- read 0x8: AR after 2 waits, R 5 cycles after RREADY
      ar_wait = 2; r_wait = 5; rdata_val = 32'h000000A5;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
      tick();                                                    // T1
      cmd_valid = 0;
      chk("rd_ar_issue", 160'({M_AXI_ARVALID, M_AXI_ARADDR}), 160'({1'b1, 32'h8}));
      lat = 0;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      chk("rd_latency", 160'(lat), 160'(9));
      chk("rd_rsp", 160'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}),
          160'({3'b100, 2'b00, 32'hA5}));
      tick(); tick();
      ar_wait = 0; r_wait = 0;

      // ---- write where W is taken 3 cycles before AW, EXOKAY response
      aw_wait = 3; bresp_val = 2'b01;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
      tick();                                                    // T1
      cmd_valid = 0;
      chk("wa_t1", 160'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 160'(3'b110));
      tick();                                                    // T2
      chk("wa_t2_w_dropped", 160'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 160'(3'b100));
      tick(); tick();                                            // T4
      chk("wa_t4_aw_pending", 160'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 160'(3'b100));
      tick();                                                    // T5
      chk("wa_t5_b_phase", 160'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 160'(3'b001));
      tick();                                                    // T6
      chk("wa_rsp", 160'({rsp_valid, rsp_write, rsp_timeout, rsp_resp}), 160'(5'b11001));
      tick(); tick();
      aw_wait = 0; bresp_val = 2'b00;

      // ---- read timeout: slave never raises ARREADY
      ar_never = 1;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'hC;
      tick();                                                    // T1
      cmd_valid = 0;
      lat = 0;
      while (M_AXI_ARVALID && lat < 40) begin lat++; tick(); end
      chk("to_arvalid_cycles", 160'(lat), 160'(16));
      chk("to_rsp", 160'({M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}),
          160'({5'b00101, 2'b10, 32'h0}));
      tick(); tick();
      chk("to_idle", 160'({cmd_ready, M_AXI_BREADY, M_AXI_RREADY, rsp_valid}), 160'(4'b1110));
      ar_never = 0;
      stray_r_req++;
      tick(); tick();
      chk("stray_r_absorbed", 160'({M_AXI_RVALID, rsp_valid, cmd_ready}), 160'(3'b001));

      // ---- response held off for 10 cycles while a second command waits
      rsp_ready = 0; rdata_val = 32'h5A5A0001;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
      tick();                                                    // T1
      cmd_valid = 0;
      tick(); tick();                                            // T3
      cmd_valid = 1; cmd_addr = 32'h24;
      for (int i = 0; i < 10; i++) begin
         chk("hold_stable", 160'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata, cmd_ready, M_AXI_ARVALID}),
             160'({3'b100, 2'b00, 32'h5A5A0001, 2'b00}));
         tick();
      end
      rsp_ready = 1; rdata_val = 32'h00000024;
      tick();
      chk("hold_release", 160'({rsp_valid, cmd_ready}), 160'(2'b00));
      tick();
      chk("second_cmd_ready", 160'(cmd_ready), 160'(1'b1));
      tick();
      cmd_valid = 0;
      chk("second_cmd_ar", 160'({M_AXI_ARVALID, M_AXI_ARADDR}), 160'({1'b1, 32'h24}));
      lat = 0;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      chk("second_rsp", 160'({rsp_valid, rsp_rdata, lat}), 160'({1'b1, 32'h24, 32'd2}));
      tick(); tick();

      // ---- reset asserted while waiting for B
      b_wait = 5;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hC;
      tick();                                                    // T1
      cmd_valid = 0;
      tick();                                                    // T2
      chk("rst_in_wrb", 160'({M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID}), 160'(3'b100));
      ARESETN = 0;
      #1;
      chk("rst_async", all_outs(), 160'(0));
      flush_req++; b_wait = 0;
      tick();
      ARESETN = 1;
      tick();
      chk("rst_recover_idle", 160'({cmd_ready, M_AXI_BREADY, M_AXI_RREADY, rsp_valid}), 160'(4'b1110));
      rdata_val = 32'h0BADF00D;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
      tick();
      cmd_valid = 0;
      chk("post_rst_ar", 160'({M_AXI_ARVALID, M_AXI_ARADDR}), 160'({1'b1, 32'h40}));
      lat = 0;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      chk("post_rst_rsp", 160'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}),
          160'({3'b100, 2'b00, 32'h0BADF00D}));
      tick(); tick();

      chk("addr_data_stable", 160'(stab_viol), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_axil_master_if
`default_nettype wire
